// File: rtl/time_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : time_display_scan
// Purpose  : Six-digit multiplexed seven-segment scan driver for a common-
//            anode HH.MM.SS clock display. All six BCD digits are captured
//            once per frame so a frame never mixes old and new time values.
//            One digit is decoded per scan slot, and the decimal point is lit
//            on the HL and ML digits to act as the separators.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   SCAN_DIV  clk cycles per digit slot (>= 2)
// Ports:
//   clk              system clock, all state on posedge
//   reset            asynchronous active-low reset
//   HH,HL,MH,ML,SH,SL  BCD time digits (hour/minute/second tens and units)
//   seg[7:0]         active-low segments, seg[7]=dp, seg[6:0]=g..a
//   sel[5:0]         active-low digit enables, sel[0]=HH ... sel[5]=SL
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, a zero hour-tens digit is blanked
// ============================================================================
module time_display_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] HH,
    input  logic [3:0] HL,
    input  logic [3:0] MH,
    input  logic [3:0] ML,
    input  logic [3:0] SH,
    input  logic [3:0] SL,
    output logic [7:0] seg,
    output logic [5:0] sel
);

    localparam int              DIV_W      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [2:0]      C_IDX_LAST = 3'd5;

    // Seven-segment pattern (g..a, active-low); non-BCD codes become a dash.
    function automatic logic [6:0] f_decode(input logic [3:0] i_val);
        logic [6:0] v;
        case (i_val)
            4'd0:    v = 7'h40;
            4'd1:    v = 7'h79;
            4'd2:    v = 7'h24;
            4'd3:    v = 7'h30;
            4'd4:    v = 7'h19;
            4'd5:    v = 7'h12;
            4'd6:    v = 7'h02;
            4'd7:    v = 7'h78;
            4'd8:    v = 7'h00;
            4'd9:    v = 7'h10;
            default: v = 7'h3F;
        endcase
        return v;
    endfunction

    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_idx;
    logic [3:0]       r_snap_hh, r_snap_hl, r_snap_mh, r_snap_ml, r_snap_sh, r_snap_sl;
    logic [7:0]       r_seg;
    logic [5:0]       r_sel;

    logic             w_wrap;
    logic             w_load;
    logic [DIV_W-1:0] w_div_nxt;
    logic [2:0]       w_idx_nxt;
    logic [3:0]       w_hh_nxt, w_hl_nxt, w_mh_nxt, w_ml_nxt, w_sh_nxt, w_sl_nxt;
    logic [3:0]       w_digit;
    logic             w_dp_n;
    logic [7:0]       w_seg_nxt;
    logic [5:0]       w_sel_nxt;

    // The outputs are computed from the post-edge index and snapshot so that
    // sel and seg always switch together on the same edge.
    always_comb begin
        w_wrap    = (r_div == C_DIV_LAST);
        w_load    = w_wrap && (r_idx == C_IDX_LAST);
        w_div_nxt = w_wrap ? '0 : r_div + 1'b1;

        w_idx_nxt = r_idx;
        if (w_wrap) begin
            w_idx_nxt = (r_idx == C_IDX_LAST) ? 3'd0 : r_idx + 3'd1;
        end

        w_hh_nxt = w_load ? HH : r_snap_hh;
        w_hl_nxt = w_load ? HL : r_snap_hl;
        w_mh_nxt = w_load ? MH : r_snap_mh;
        w_ml_nxt = w_load ? ML : r_snap_ml;
        w_sh_nxt = w_load ? SH : r_snap_sh;
        w_sl_nxt = w_load ? SL : r_snap_sl;

        case (w_idx_nxt)
            3'd0:    w_digit = w_hh_nxt;
            3'd1:    w_digit = w_hl_nxt;
            3'd2:    w_digit = w_mh_nxt;
            3'd3:    w_digit = w_ml_nxt;
            3'd4:    w_digit = w_sh_nxt;
            default: w_digit = w_sl_nxt;
        endcase

        // Separator dots sit after the hour-units and minute-units digits.
        w_dp_n    = !((w_idx_nxt == 3'd1) || (w_idx_nxt == 3'd3));
        w_seg_nxt = {w_dp_n, f_decode(w_digit)};
`ifdef LEADING_ZERO_BLANK_EN
        if ((w_idx_nxt == 3'd0) && (w_hh_nxt == 4'd0)) begin
            w_seg_nxt = 8'hFF;
        end
`endif
        w_sel_nxt = ~(6'b000001 << w_idx_nxt);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div     <= '0;
            r_idx     <= 3'd0;
            r_snap_hh <= 4'd0;
            r_snap_hl <= 4'd0;
            r_snap_mh <= 4'd0;
            r_snap_ml <= 4'd0;
            r_snap_sh <= 4'd0;
            r_snap_sl <= 4'd0;
            r_seg     <= 8'hFF;
            r_sel     <= 6'b111111;
        end else begin
            r_div     <= w_div_nxt;
            r_idx     <= w_idx_nxt;
            r_snap_hh <= w_hh_nxt;
            r_snap_hl <= w_hl_nxt;
            r_snap_mh <= w_mh_nxt;
            r_snap_ml <= w_ml_nxt;
            r_snap_sh <= w_sh_nxt;
            r_snap_sl <= w_sl_nxt;
            r_seg     <= w_seg_nxt;
            r_sel     <= w_sel_nxt;
        end
    end

    assign seg = r_seg;
    assign sel = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_time_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_display_scan
// Purpose  : Directed self-checking bench for time_display_scan. Two
//            instances share stimulus: SCAN_DIV=4 for the functional scenarios
//            and SCAN_DIV=2 for the divider-bound scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_time_display_scan;

    logic       clk;
    logic       reset;
    logic [3:0] HH, HL, MH, ML, SH, SL;
    logic [7:0] seg, seg2;
    logic [5:0] sel, sel2;

    int n_cmp;
    int n_err;
    int edge_cnt;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] C_HH0 = 8'hFF;
`else
    localparam logic [7:0] C_HH0 = 8'hC0;
`endif

    time_display_scan #(.SCAN_DIV(4)) dut (
        .clk(clk), .reset(reset),
        .HH(HH), .HL(HL), .MH(MH), .ML(ML), .SH(SH), .SL(SL),
        .seg(seg), .sel(sel)
    );

    time_display_scan #(.SCAN_DIV(2)) dut2 (
        .clk(clk), .reset(reset),
        .HH(HH), .HL(HL), .MH(MH), .ML(ML), .SH(SH), .SL(SL),
        .seg(seg2), .sel(sel2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

    // Advance one clock edge and sample on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        edge_cnt++;
    endtask

    task automatic goto_edge(input int target);
        while (edge_cnt < target) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        HH = 4'd1; HL = 4'd2; MH = 4'd3; ML = 4'd4; SH = 4'd5; SL = 4'd9;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (sel !== 6'h3F || seg !== 8'hFF) begin
            n_err++;
            $display("FAIL reset_async: sel=%h seg=%h, required sel=3F seg=FF", sel, seg);
        end
        n_cmp++;
        if (sel2 !== 6'h3F || seg2 !== 8'hFF) begin
            n_err++;
            $display("FAIL reset_async2: sel=%h seg=%h, required sel=3F seg=FF", sel2, seg2);
        end
        @(negedge clk);
        reset = 1'b1;
        edge_cnt = 0;
        step();
        n_cmp++;
        if (sel !== 6'h3E || seg !== C_HH0) begin
            n_err++;
            $display("FAIL reset_first_edge: sel=%h seg=%h, required sel=3E seg=%h", sel, seg, C_HH0);
        end
    endtask

    task automatic test_scan_order();
        logic [5:0] exp_sel [6];
        logic [7:0] exp_seg [6];
        exp_sel = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
        exp_seg = '{8'hF9, 8'h24, 8'hB0, 8'h19, 8'h92, 8'h90};
        for (int i = 0; i < 24; i++) begin
            goto_edge(24 + i);
            n_cmp++;
            if (sel !== exp_sel[i/4] || seg !== exp_seg[i/4]) begin
                n_err++;
                $display("FAIL scan_order edge %0d: sel=%h seg=%h, required sel=%h seg=%h",
                         edge_cnt, sel, seg, exp_sel[i/4], exp_seg[i/4]);
            end
        end
    endtask

    task automatic test_snapshot();
        goto_edge(50);
        HL = 4'd7;
        for (int i = 0; i < 4; i++) begin
            goto_edge(52 + i);
            n_cmp++;
            if (sel !== 6'h3D || seg !== 8'h24) begin
                n_err++;
                $display("FAIL snapshot_hold edge %0d: sel=%h seg=%h, required sel=3D seg=24",
                         edge_cnt, sel, seg);
            end
        end
        goto_edge(76);
        n_cmp++;
        if (sel !== 6'h3D || seg !== 8'h78) begin
            n_err++;
            $display("FAIL snapshot_next: sel=%h seg=%h, required sel=3D seg=78", sel, seg);
        end
    endtask

    task automatic test_invalid_bcd();
        MH = 4'hF;
        SL = 4'hC;
        goto_edge(104);
        n_cmp++;
        if (sel !== 6'h3B || seg !== 8'hBF) begin
            n_err++;
            $display("FAIL invalid_mh: sel=%h seg=%h, required sel=3B seg=BF", sel, seg);
        end
        goto_edge(108);
        n_cmp++;
        if (sel !== 6'h37 || seg !== 8'h19) begin
            n_err++;
            $display("FAIL valid_ml: sel=%h seg=%h, required sel=37 seg=19", sel, seg);
        end
        goto_edge(116);
        n_cmp++;
        if (sel !== 6'h1F || seg !== 8'hBF) begin
            n_err++;
            $display("FAIL invalid_sl: sel=%h seg=%h, required sel=1F seg=BF", sel, seg);
        end
    endtask

    task automatic test_leading_zero();
        HH = 4'd0;
        HL = 4'd8;
        goto_edge(120);
        n_cmp++;
        if (sel !== 6'h3E || seg !== C_HH0) begin
            n_err++;
            $display("FAIL leading_zero: sel=%h seg=%h, required sel=3E seg=%h", sel, seg, C_HH0);
        end
        goto_edge(124);
        n_cmp++;
        if (sel !== 6'h3D || seg !== 8'h00) begin
            n_err++;
            $display("FAIL hl_eight_dp: sel=%h seg=%h, required sel=3D seg=00", sel, seg);
        end
    endtask

    task automatic test_divider_bound();
        logic [5:0] exp_sel;
        logic [7:0] exp_seg;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (sel2 !== 6'h3F || seg2 !== 8'hFF) begin
            n_err++;
            $display("FAIL reset_midscan2: sel=%h seg=%h, required sel=3F seg=FF", sel2, seg2);
        end
        @(negedge clk);
        reset = 1'b1;
        edge_cnt = 0;
        // Inputs now: HH=0 HL=8 MH=F ML=4 SH=5 SL=C
        for (int k = 1; k <= 24; k++) begin
            goto_edge(k);
            exp_sel = ~(6'b000001 << ((k / 2) % 6));
            n_cmp++;
            if (sel2 !== exp_sel) begin
                n_err++;
                $display("FAIL div2_sel edge %0d: sel=%h, required %h", k, sel2, exp_sel);
            end
            exp_seg = 8'h00;
            case (k)
                11: exp_seg = 8'hC0;   // zeroed snapshot, digit 5
                12: exp_seg = 8'hB0;   // first load, HH=3
                23: exp_seg = 8'hBF;   // SL=C as dash
                24: exp_seg = 8'hF8;   // second load, HH=7
                default: ;
            endcase
            if (k == 11 || k == 12 || k == 23 || k == 24) begin
                n_cmp++;
                if (seg2 !== exp_seg) begin
                    n_err++;
                    $display("FAIL div2_seg edge %0d: seg=%h, required %h", k, seg2, exp_seg);
                end
            end
            if (k == 5)  HH = 4'd3;
            if (k == 13) HH = 4'd7;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        edge_cnt = 0;
        test_reset();
        test_scan_order();
        test_snapshot();
        test_invalid_bcd();
        test_leading_zero();
        test_divider_bound();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/time_display_scan.md
# time_display_scan

Six-digit multiplexed seven-segment scan driver that consumes the BCD time digits produced by the hour/minute/second counters: HH, HL, MH, ML, SH and SL. It snapshots all six digits once per frame so the display never tears, decodes one digit per scan slot, and drives a common-anode display with active-low segment and digit-select lines. It sits between the timekeeping counters and the board's display pins.

## Interface
- SCAN_DIV, 50000, clk cycles per digit slot; legal range ≥ 2.
- clk  input  1  system clock; all state on posedge.
- reset  input  1  asynchronous, active-low reset.
- HH  input  4  hour tens, BCD.
- HL  input  4  hour units, BCD.
- MH  input  4  minute tens, BCD.
- ML  input  4  minute units, BCD.
- SH  input  4  second tens, BCD.
- SL  input  4  second units, BCD.
- seg  output  8  active-low segments: seg[7]=dp, seg[6:0]=g,f,e,d,c,b,a.
- sel  output  6  active-low digit enables: sel[0]=HH (leftmost) … sel[5]=SL.

## Operation
- Divider `div` counts 0..SCAN_DIV-1, then wraps to 0.
- On the wrap edge, digit index `idx` advances 0→1→…→5→0.
- Snapshot: on the edge where `div`==SCAN_DIV-1 and `idx`==5, all six inputs are latched into snapshot registers, and `idx` becomes 0 in the same edge. Inputs are ignored at all other times.
- Digit mapping: idx 0..5 selects snapshot HH, HL, MH, ML, SH, SL.
- Decode of seg[7:0], before the dp bit is applied:
  - 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90.
  - Codes 10–15 → BF, a dash (segment g only).
- Decimal point: seg[7] is driven 0 (lit) on idx 1 and idx 3 to act as the HH:MM:SS separators. It is 1 on all other digits, including on dash digits.
- sel: exactly one bit is low, bit `idx`.
- Reset (async assert, any time): div=0, idx=0, snapshot=0, sel=6'b111111, seg=8'hFF.
- Reset deassertion mid-frame restarts the frame at idx 0.
- The first frame after reset shows the zeroed snapshot, 00.00.00. Live inputs appear from the second frame.

## Timing
- seg and sel are registered; each is a function of the post-edge `idx` and snapshot, with 1 cycle of latency.
- First clk edge after reset release: sel=6'b111110, seg=C0 (digit 0, value 0).
- Each digit is held for exactly SCAN_DIV cycles. The frame period is 6×SCAN_DIV cycles.
- Input change to display: the change shows at the next snapshot edge, i.e. at most one frame plus 1 cycle later.
- sel and seg change on the same edge, so there is no cycle where a new sel shows an old seg.

## Configuration
- LEADING_ZERO_BLANK_EN
  - Defined: when the snapshot HH equals 0, the idx 0 slot drives seg=FF (blank) while sel[0] stays low. All other digits are unaffected.
  - Undefined: HH=0 displays C0 as normal.

## Test plan
- Reset: assert reset mid-scan with SCAN_DIV=4 → sel=3F and seg=FF immediately, without waiting for a clock edge. First edge after release → sel=3E, seg=C0.
- Scan order: SCAN_DIV=4, inputs 1,2,3,4,5,9.
  - After the first frame, sel steps 3E,3D,3B,37,2F,1F, holding each for 4 cycles.
  - seg steps F9, 24, B0, 19, 92, 90, with dp lit on digits 1 and 3.
- Snapshot coherence: change HL from 2 to 7 in the middle of the frame → the current frame still shows 24 on digit 1. The next frame shows 78.
- Invalid BCD: SL=4'hC → digit 5 shows BF. Invalid MH=4'hF → digit 2 shows BF.
- Macro: HH=0, HL=8.
  - With LEADING_ZERO_BLANK_EN: digit 0 shows seg=FF with sel=3E.
  - Without it: digit 0 shows C0.
  - Digit 1 shows 00 in both builds.
- Divider bound: SCAN_DIV=2 → each sel value lasts exactly 2 cycles. The snapshot loads every 12 cycles.
